// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller: zero-fill sweep after reset, then
// one byte/half/word/dword load or store per request with alignment checks.
module data_mem_ctrl #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_INIT, S_IDLE, S_ACCESS, S_RESP
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              init_we, mem_we;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IW-1:0]     idx;
  logic [OFF-1:0]    off;
  logic [OFF-1:0]    amask;
  logic              err;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] ld;
  logic              sb;

  assign idx   = req_q.addr[OFF+IW-1:OFF];
  assign off   = req_q.addr[OFF-1:0];
  assign amask = OFF'((1 << req_q.size) - 1);

  // Range, alignment and size checks all work on the captured request.
  always_comb begin
    err = |(req_q.addr >> (OFF + IW));
    err = err | (|(off & amask));
    err = err | ((DATA_W == 32) && (req_q.size == 2'b11));
  end

  always_comb begin
    be  = NB'(((1 << (1 << req_q.size)) - 1) << off);
    wsh = req_q.wdata << {off, 3'b000};
    raw = mem_q[idx] >> {off, 3'b000};
    unique case (req_q.size)
      2'b00:   sb = raw[7];
      2'b01:   sb = raw[15];
      2'b10:   sb = raw[31];
      default: sb = raw[DATA_W-1];
    endcase
    ld = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ld[i] = (i < (8 << req_q.size)) ? raw[i] : (req_q.sgn & sb);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    init_we = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == IW'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid) begin
          req_d = '{wr: req_write, addr: req_addr, size: req_size,
                    sgn: req_signed, wdata: req_wdata};
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        err_d   = err;
        rdata_d = (err || req_q.wr) ? '0 : ld;
        mem_we  = !err && req_q.wr;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    init_done  = (state_q != S_INIT);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  always_ff @(posedge clock) begin
    if (init_we) begin
      mem_q[cnt_q] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wsh[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: vector table plus reset,
// backpressure and sweep sequences.
module tb_data_mem_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(64), .DEPTH(DEPTH), .ADDR_W(64)) dut (
    .clock(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .init_done(init_done)
  );

  typedef struct {
    string       nm;
    logic        w;
    logic [63:0] a;
    logic [1:0]  s;
    logic        sg;
    logic [63:0] wd;
    logic [63:0] rd;
    logic        er;
  } vec_t;

  vec_t v[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic w, input logic [63:0] a,
                     input logic [1:0] s, input logic sg,
                     input logic [63:0] wd, input logic [63:0] rd,
                     input logic er);
    vec_t t;
    t.nm = nm; t.w = w; t.a = a; t.s = s;
    t.sg = sg; t.wd = wd; t.rd = rd; t.er = er;
    v.push_back(t);
  endtask

  task automatic issue(input logic w, input logic [63:0] a,
                       input logic [1:0] s, input logic sg,
                       input logic [63:0] wd);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a;
    req_size = s; req_signed = sg; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("hs_timeout", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~w; req_addr = ~a;
    req_size = ~s; req_signed = ~sg; req_wdata = ~wd;
    chk("lat_early", {62'd0, resp_valid, req_ready}, 64'd0);
    @(posedge clk); #1;
    chk("lat_resp", 64'(resp_valid), 64'd1);
  endtask

  task automatic xact(input logic w, input logic [63:0] a,
                      input logic [1:0] s, input logic sg,
                      input logic [63:0] wd,
                      output logic [63:0] rd, output logic er);
    issue(w, a, s, sg, wd);
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic init_sweep(input string nm);
    bit early;
    early = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk); #1;
      if (k < DEPTH && (req_ready || init_done)) early = 1'b1;
    end
    chk({nm, "_busy"}, 64'(early), 64'd0);
    chk({nm, "_done"}, {62'd0, req_ready, init_done}, 64'd3);
  endtask

  logic [63:0] rd;
  logic        er;

  initial begin
    add("st_dw40",   1, 64'h40, 2'd3, 0, 64'h1122334455667788, 0, 0);
    add("ldb43_u",   0, 64'h43, 2'd0, 0, 0, 64'h55, 0);
    add("ldb43_s",   0, 64'h43, 2'd0, 1, 0, 64'h55, 0);
    add("ld_dw40",   0, 64'h40, 2'd3, 0, 0, 64'h1122334455667788, 0);
    add("ldh46_u",   0, 64'h46, 2'd1, 0, 0, 64'h1122, 0);
    add("ldw44_s",   0, 64'h44, 2'd2, 1, 0, 64'h11223344, 0);
    add("ldb40_s",   0, 64'h40, 2'd0, 1, 0, 64'hFFFFFFFFFFFFFF88, 0);
    add("st_dw10",   1, 64'h10, 2'd3, 0, 64'hA0A1A2A3A4A5A6A7, 0, 0);
    add("st_h12",    1, 64'h12, 2'd1, 0, 64'hDEADBEEFCAFE8001, 0, 0);
    add("ldh12_s",   0, 64'h12, 2'd1, 1, 0, 64'hFFFFFFFFFFFF8001, 0);
    add("ldh12_u",   0, 64'h12, 2'd1, 0, 0, 64'h8001, 0);
    add("ld_dw10",   0, 64'h10, 2'd3, 0, 0, 64'hA0A1A2A3_8001A6A7, 0);
    add("err_ldw6",  0, 64'h6,  2'd2, 0, 0, 0, 1);
    add("err_ld2k",  0, 64'h2000, 2'd3, 0, 0, 0, 1);
    add("err_st2k",  1, 64'h2000, 2'd3, 0, 64'hFFFFFFFFFFFFFFFF, 0, 1);
    add("ld_dw0",    0, 64'h0,  2'd3, 0, 0, 0, 0);
    add("err_stw42", 1, 64'h42, 2'd2, 0, 64'hFFFFFFFF, 0, 1);
    add("err_sd44",  1, 64'h44, 2'd3, 0, 64'hFFFFFFFFFFFFFFFF, 0, 1);
    add("err_ldh13", 0, 64'h13, 2'd1, 1, 0, 0, 1);
    add("err_hibit", 0, 64'h8000000000000040, 2'd0, 0, 0, 0, 1);
    add("ld_dw40b",  0, 64'h40, 2'd3, 0, 0, 64'h1122334455667788, 0);
    add("st_b47",    1, 64'h47, 2'd0, 0, 64'h123456789ABCDE5A, 0, 0);
    add("ld_dw40c",  0, 64'h40, 2'd3, 0, 0, 64'h5A22334455667788, 0);
    add("st_w14",    1, 64'h14, 2'd2, 0, 64'h87654321, 0, 0);
    add("ldw14_u",   0, 64'h14, 2'd2, 0, 0, 64'h87654321, 0);
    add("ldw14_s",   0, 64'h14, 2'd2, 1, 0, 64'hFFFFFFFF87654321, 0);
    add("ld_dw10b",  0, 64'h10, 2'd3, 0, 0, 64'h87654321_8001A6A7, 0);
    add("st_top",    1, 64'h1FF8, 2'd3, 0, 64'h0123456789ABCDEF, 0, 0);
    add("ld_top",    0, 64'h1FF8, 2'd3, 0, 0, 64'h0123456789ABCDEF, 0);

    #3;
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_rvalid", 64'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", 64'(resp_err), 0);
    chk("rst_done", 64'(init_done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    init_sweep("init");

    for (int i = 0; i < DEPTH; i++) begin
      xact(0, 64'(i * 8), 2'd3, 0, 0, rd, er);
      chk("sweep_zero", {rd[62:0], er}, 0);
    end

    foreach (v[i]) begin
      xact(v[i].w, v[i].a, v[i].s, v[i].sg, v[i].wd, rd, er);
      chk({v[i].nm, "_data"}, rd, v[i].rd);
      chk({v[i].nm, "_err"}, 64'(er), 64'(v[i].er));
    end

    // Backpressure with a stray request that must be ignored.
    issue(0, 64'h40, 2'd3, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40;
    req_size = 2'd3; req_wdata = 64'hDEAD;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", {62'd0, resp_valid, req_ready}, 64'd2);
      chk("bp_data", resp_rdata, 64'h5A22334455667788);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_idle", {62'd0, resp_valid, req_ready}, 64'd1);
    xact(0, 64'h40, 2'd3, 0, 0, rd, er);
    chk("bp_nowrite", rd, 64'h5A22334455667788);

    // Reset while a response is pending.
    issue(0, 64'h40, 2'd3, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_drop", {61'd0, resp_valid, req_ready, init_done}, 0);
    chk("midrst_data", {resp_rdata[62:0], resp_err}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    init_sweep("reinit");
    xact(0, 64'h40, 2'd3, 0, 0, rd, er);
    chk("reinit_clr40", rd, 0);
    xact(0, 64'h1FF8, 2'd3, 0, 0, rd, er);
    chk("reinit_clrtop", rd, 0);

    // Reset part-way through the sweep restarts it from word 0.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("initrst_done", 64'(init_done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    init_sweep("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
